// File: rtl/program_loader.sv
// Byte-stream program loader: assembles instruction words and writes them into program memory,
// holding the CPU until done. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module program_loader #(
    parameter int unsigned O_SIZE = 6,
    parameter int unsigned R_SIZE = 3,
    parameter int unsigned N      = 8,
    parameter int unsigned P_SIZE = 5,
    localparam int unsigned I_SIZE = O_SIZE + R_SIZE + N,
    localparam int unsigned BPW    = (I_SIZE + 7) / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byteIn,
    input  logic              byteValid,
    output logic              byteAck,
    output logic              pmWriteEn,
    output logic [P_SIZE-1:0] pmWriteAddr,
    output logic [I_SIZE-1:0] pmWriteData,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              loadError
);

    localparam int unsigned SW = BPW * 8;
    localparam int unsigned IW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        StLoadCount,
        StLoadByte,
        StWrite,
        StDone,
        StError
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , StCheck
`endif
    } state_t;

    state_t            state_q;
    logic              prev_valid_q;
    logic [IW-1:0]     idx_q;
    logic [SW-1:0]     shift_q;
    logic [SW-1:0]     shift_next;
    logic [P_SIZE-1:0] last_addr_q;
    logic              accept;
    logic              count_too_big;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    always_comb begin
        accept = 1'b0;
        if (byteValid && !prev_valid_q) begin
            case (state_q)
                StLoadCount, StLoadByte: accept = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                StCheck:                 accept = 1'b1;
`endif
                default:                 accept = 1'b0;
            endcase
        end
    end

    assign shift_next    = (shift_q << 8) | SW'(byteIn);
    assign count_too_big = {24'd0, byteIn} > (32'd1 << P_SIZE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLoadCount;
            prev_valid_q <= 1'b0;
            idx_q        <= '0;
            shift_q      <= '0;
            last_addr_q  <= '0;
            byteAck      <= 1'b0;
            pmWriteEn    <= 1'b0;
            pmWriteAddr  <= '0;
            pmWriteData  <= '0;
            cpuHold      <= 1'b1;
            loadDone     <= 1'b0;
            loadError    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            prev_valid_q <= byteValid;
            byteAck      <= accept;
            pmWriteEn    <= 1'b0;
            case (state_q)
                StLoadCount: begin
                    if (accept) begin
                        if (count_too_big) begin
                            state_q   <= StError;
                            loadError <= 1'b1;
                        end else begin
                            // A count of zero means the full memory.
                            last_addr_q <= (byteIn == 8'd0) ? '1 : P_SIZE'(byteIn - 8'd1);
                            state_q     <= StLoadByte;
                        end
                    end
                end
                StLoadByte: begin
                    if (accept) begin
                        shift_q <= shift_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        xor_q   <= xor_q ^ byteIn;
`endif
                        if (idx_q == IW'(BPW - 1)) begin
                            idx_q       <= '0;
                            state_q     <= StWrite;
                            pmWriteEn   <= 1'b1;
                            pmWriteData <= shift_next[I_SIZE-1:0];
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (pmWriteAddr == last_addr_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_q  <= StCheck;
`else
                        state_q  <= StDone;
                        cpuHold  <= 1'b0;
                        loadDone <= 1'b1;
`endif
                    end else begin
                        pmWriteAddr <= pmWriteAddr + P_SIZE'(1);
                        state_q     <= StLoadByte;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        if (byteIn == xor_q) begin
                            state_q  <= StDone;
                            cpuHold  <= 1'b0;
                            loadDone <= 1'b1;
                        end else begin
                            state_q   <= StError;
                            loadError <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven single-word loads plus scoreboarded
// multi-word sequences; define PROGRAM_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteAck;
    logic        pmWriteEn;
    logic [4:0]  pmWriteAddr;
    logic [16:0] pmWriteData;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .byteIn      (byteIn),
        .byteValid   (byteValid),
        .byteAck     (byteAck),
        .pmWriteEn   (pmWriteEn),
        .pmWriteAddr (pmWriteAddr),
        .pmWriteData (pmWriteData),
        .cpuHold     (cpuHold),
        .loadDone    (loadDone),
        .loadError   (loadError)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [16:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [16:0] exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    int   acks   = 0;
    wr_t  exp_q[$];
    logic [7:0] run_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write pulse pops the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (byteAck) acks++;
        if (pmWriteEn) begin
            wr_t e;
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         pmWriteAddr, pmWriteData);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(pmWriteAddr), 32'(e.addr));
                check("write_data", 32'(pmWriteData), 32'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        byteValid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        writes  = 0;
        acks    = 0;
        run_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 byteIn = b;
        byteValid = 1'b1;
        repeat (2) @(posedge clk);
        #1 byteValid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        run_xor = run_xor ^ b;
        send_byte(b);
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [4:0] addr, input logic [16:0] exp);
        exp_q.push_back('{addr: addr, data: exp});
        send_data(b0);
        send_data(b1);
        send_data(b2);
    endtask

    task automatic finish_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic wait_end(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (loadDone || loadError) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_end: no loadDone/loadError within %0d cycles", limit);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"},   32'(pmWriteEn),   32'd0);
        check({tag, "_addr"},  32'(pmWriteAddr), 32'd0);
        check({tag, "_data"},  32'(pmWriteData), 32'd0);
        check({tag, "_ack"},   32'(byteAck),     32'd0);
        check({tag, "_hold"},  32'(cpuHold),     32'd1);
        check({tag, "_done"},  32'(loadDone),    32'd0);
        check({tag, "_error"}, 32'(loadError),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [7:0] b0, b1, b2;
        int k;

        vecs[0] = '{8'h01, 8'h23, 8'h45, 17'h12345};
        vecs[1] = '{8'h00, 8'hFF, 8'h0F, 17'h0FF0F};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 17'h1FFFF};
        vecs[3] = '{8'hFE, 8'h00, 8'h01, 17'h00001};
        vecs[4] = '{8'h03, 8'hAB, 8'hCD, 17'h1ABCD};

        reset     = 1'b1;
        byteValid = 1'b0;
        byteIn    = 8'h00;
        run_xor   = 8'h00;

        do_reset();
        @(negedge clk);
        check_reset_vals("reset");

        // Two-word load.
        send_byte(8'h02);
        send_word(8'h01, 8'h23, 8'h45, 5'd0, 17'h12345);
        send_word(8'h00, 8'hFF, 8'h0F, 5'd1, 17'h0FF0F);
        finish_load();
        wait_end(50);
        check("two_word_writes", 32'(writes),       32'd2);
        check("two_word_done",   32'(loadDone),     32'd1);
        check("two_word_hold",   32'(cpuHold),      32'd0);
        check("two_word_error",  32'(loadError),    32'd0);
        check("two_word_queue",  32'(exp_q.size()), 32'd0);

        // Table-driven single-word loads.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_byte(8'h01);
            send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, 5'd0, vecs[v].exp);
            finish_load();
            wait_end(50);
            check("vec_done",   32'(loadDone), 32'd1);
            check("vec_writes", 32'(writes),   32'd1);
        end

        // Count 0 means 32 words; address must stop at 31.
        do_reset();
        send_byte(8'h00);
        k = 0;
        for (int w = 0; w < 32; w++) begin
            b0 = 8'(k * 37 + 5);
            b1 = 8'((k + 1) * 37 + 5);
            b2 = 8'((k + 2) * 37 + 5);
            k  = k + 3;
            send_word(b0, b1, b2, 5'(w), {b0[0], b1, b2});
        end
        finish_load();
        wait_end(50);
        check("full_writes", 32'(writes),      32'd32);
        check("full_done",   32'(loadDone),    32'd1);
        check("full_addr",   32'(pmWriteAddr), 32'd31);
        repeat (5) @(negedge clk);
        check("full_addr_hold", 32'(pmWriteAddr), 32'd31);

        // Oversized count.
        do_reset();
        send_byte(8'h21);
        @(negedge clk);
        check("big_error", 32'(loadError), 32'd1);
        check("big_hold",  32'(cpuHold),   32'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        @(negedge clk);
        check("big_writes", 32'(writes),    32'd0);
        check("big_acks",   32'(acks),      32'd1);
        check("big_sticky", 32'(loadError), 32'd1);
        check("big_done",   32'(loadDone),  32'd0);

        // Held strobe yields one byte per rising level.
        do_reset();
        @(posedge clk);
        #1 byteIn = 8'h02;
        byteValid = 1'b1;
        repeat (10) @(posedge clk);
        #1 byteValid = 1'b0;
        byteIn = 8'hAA;
        repeat (3) @(posedge clk);
        #1 byteValid = 1'b1;
        repeat (3) @(posedge clk);
        #1 byteValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_acks", 32'(acks),   32'd2);
        check("held_writes", 32'(writes), 32'd0);
        exp_q.push_back('{addr: 5'd0, data: 17'h01122});
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        check("held_word_writes", 32'(writes), 32'd1);
        check("held_acks_total",  32'(acks),   32'd4);

        // Reset in the middle of word 1.
        do_reset();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        writes  = 0;
        acks    = 0;
        run_xor = 8'h00;
        send_byte(8'h01);
        send_word(8'h33, 8'h44, 8'h55, 5'd0, 17'h14455);
        finish_load();
        wait_end(50);
        check("midreset_done",   32'(loadDone), 32'd1);
        check("midreset_writes", 32'(writes),   32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_reset();
        send_byte(8'h01);
        send_word(8'h01, 8'h02, 8'h04, 5'd0, 17'h10204);
        @(negedge clk);
        check("cks_hold_wait", 32'(cpuHold), 32'd1);
        send_byte(8'h07);
        wait_end(50);
        check("cks_good_done",  32'(loadDone),  32'd1);
        check("cks_good_error", 32'(loadError), 32'd0);

        do_reset();
        send_byte(8'h01);
        send_word(8'h01, 8'h02, 8'h04, 5'd0, 17'h10204);
        send_byte(8'h06);
        wait_end(50);
        check("cks_bad_error", 32'(loadError), 32'd1);
        check("cks_bad_hold",  32'(cpuHold),   32'd1);
        check("cks_bad_done",  32'(loadDone),  32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
